// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// RN_W and CNT_W are the register-number and statistics-counter widths.
package pipe_ctrl_pkg;

  localparam int unsigned RN_W  = 5;
  localparam int unsigned CNT_W = 32;

  // Operand select encoding
  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EALU = 2'd1;
  localparam logic [1:0] FWD_MALU = 2'd2;
  localparam logic [1:0] FWD_MMEM = 2'd3;

  // Destination info carried down the pipe alongside each instruction
  typedef struct packed {
    logic [RN_W-1:0] rn;
    logic            wreg;
    logic            m2reg;
  } dest_info_t;

  // Forward select for one source operand; EX wins over MEM, r0 never matches.
  // A load sitting in EX is not forwardable; that case is caught by the stall logic.
  function automatic logic [1:0] fwd_sel(input logic [RN_W-1:0] src,
                                         input logic            use_src,
                                         input dest_info_t      e,
                                         input dest_info_t      m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && (src != '0)) begin
      if (e.wreg && (e.rn == src) && !e.m2reg) begin
        sel = FWD_EALU;
      end else if (m.wreg && (m.rn == src)) begin
        sel = m.m2reg ? FWD_MMEM : FWD_MALU;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / control-response bundle between the pipeline and the
// hazard controller. Statistics counters exist only when HAZARD_CNT_EN is defined.
interface pipe_hazard_ctrl_if import pipe_ctrl_pkg::*; ;

  // ID-stage instruction info
  logic [RN_W-1:0]  rs;
  logic [RN_W-1:0]  rt;
  logic             use_rs;
  logic             use_rt;
  logic             dwreg;
  logic             dm2reg;
  logic [RN_W-1:0]  drn;
  logic             mem_wait;

  // Controller responses
  logic             wpcir;
  logic             de_en;
  logic             de_bubble;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwd_cnt;
`endif

  // Pipeline side
  modport master (
    output rs, rt, use_rs, use_rt, dwreg, dm2reg, drn, mem_wait,
`ifdef HAZARD_CNT_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  wpcir, de_en, de_bubble, fwda, fwdb
  );

  // Controller side
  modport slave (
    input  rs, rt, use_rs, use_rt, dwreg, dm2reg, drn, mem_wait,
`ifdef HAZARD_CNT_EN
    output stall_cnt, fwd_cnt,
`endif
    output wpcir, de_en, de_bubble, fwda, fwdb
  );

endinterface

// File: rtl/pipe_ctrl_shadow.sv
// One pipeline stage worth of destination info (rn, wreg, m2reg) with
// load enable and a synchronous clear used to insert a bubble.
module pipe_ctrl_shadow import pipe_ctrl_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  dest_info_t d_i,
  output dest_info_t q_o
);

  dest_info_t info_q, info_d;

  // Next state: hold unless enabled; clear takes precedence over load
  always_comb begin
    info_d = info_q;
    if (en_i) begin
      info_d = clr_i ? '0 : d_i;
    end
  end

  // Stage register with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      info_q <= '0;
    end else begin
      info_q <= info_d;
    end
  end

  assign q_o = info_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding controller for the 5-stage pipeline. Tracks EX and MEM
// destination info, detects load-use hazards, injects ID->EX bubbles, selects
// operand forwarding, and freezes everything while data memory is busy.
// Branches use a delay slot, so nothing is flushed here.
// Optional HAZARD_CNT_EN adds stall / forward statistics counters.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  dest_info_t e_info, m_info, id_info;
  logic       ldst;
  logic       shadow_en;
  logic [1:0] fwda, fwdb;

  assign id_info = '{rn: bus.drn, wreg: bus.dwreg, m2reg: bus.dm2reg};

  // Load in EX feeding an operand the ID instruction reads
  always_comb begin
    ldst = e_info.wreg && e_info.m2reg && (e_info.rn != '0) &&
           ((bus.use_rs && (e_info.rn == bus.rs)) || (bus.use_rt && (e_info.rn == bus.rt)));
  end

  // Shadow stages advance only when memory is not stalling the pipe
  assign shadow_en = !bus.mem_wait;

  pipe_ctrl_shadow u_e_stage (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (shadow_en),
    .clr_i (ldst),
    .d_i   (id_info),
    .q_o   (e_info)
  );

  pipe_ctrl_shadow u_m_stage (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (shadow_en),
    .clr_i (1'b0),
    .d_i   (e_info),
    .q_o   (m_info)
  );

  // Forwarding selects per source operand
  always_comb begin
    fwda = fwd_sel(bus.rs, bus.use_rs, e_info, m_info);
    fwdb = fwd_sel(bus.rt, bus.use_rt, e_info, m_info);
  end

  assign bus.fwda = fwda;
  assign bus.fwdb = fwdb;

  // Pipeline enables: freeze beats load-use stall, which beats normal flow
  always_comb begin
    bus.wpcir     = 1'b1;
    bus.de_en     = 1'b1;
    bus.de_bubble = 1'b0;
    if (bus.mem_wait) begin
      bus.wpcir = 1'b0;
      bus.de_en = 1'b0;
    end else if (ldst) begin
      bus.wpcir     = 1'b0;
      bus.de_bubble = 1'b1;
    end
  end

`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Count qualifying cycles; frozen cycles are ignored, counters wrap naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!bus.mem_wait) begin
      if (ldst) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((fwda != FWD_RF) || (fwdb != FWD_RF)) begin
        fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl. Each row is one clock:
// ID inputs are driven after the rising edge, outputs checked on the falling edge.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clock;
  logic reset;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs;
    logic       use_rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       dwreg;
    logic       dm2reg;
    logic [4:0] drn;
    logic       mem_wait;
    logic       e_wpcir;
    logic       e_de_en;
    logic       e_bub;
    logic [1:0] e_fwda;
    logic [1:0] e_fwdb;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;
  int   idx_t3;
  int   idx_rst;

  function automatic vec_t mk(input string nm, input logic rst,
                              input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt,
                              input logic dw, input logic dm, input logic [4:0] drn,
                              input logic mw, input logic wp, input logic en,
                              input logic bub, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.name = nm; v.rst = rst; v.rs = rs; v.use_rs = urs; v.rt = rt; v.use_rt = urt;
    v.dwreg = dw; v.dm2reg = dm; v.drn = drn; v.mem_wait = mw;
    v.e_wpcir = wp; v.e_de_en = en; v.e_bub = bub; v.e_fwda = fa; v.e_fwdb = fb;
    return v;
  endfunction

  // Drive one cycle, compare on the falling edge, then advance past the rising edge
  task automatic step(input vec_t v);
    reset        = v.rst;
    bus.rs       = v.rs;
    bus.use_rs   = v.use_rs;
    bus.rt       = v.rt;
    bus.use_rt   = v.use_rt;
    bus.dwreg    = v.dwreg;
    bus.dm2reg   = v.dm2reg;
    bus.drn      = v.drn;
    bus.mem_wait = v.mem_wait;
    @(negedge clock);
    n_vec++;
    if ((bus.wpcir !== v.e_wpcir) || (bus.de_en !== v.e_de_en) ||
        (bus.de_bubble !== v.e_bub) || (bus.fwda !== v.e_fwda) || (bus.fwdb !== v.e_fwdb)) begin
      n_err++;
      $display("FAIL %s: got wpcir=%b de_en=%b bubble=%b fwda=%0d fwdb=%0d, want %b %b %b %0d %0d",
               v.name, bus.wpcir, bus.de_en, bus.de_bubble, bus.fwda, bus.fwdb,
               v.e_wpcir, v.e_de_en, v.e_bub, v.e_fwda, v.e_fwdb);
    end
    @(posedge clock);
    #1;
  endtask

`ifdef HAZARD_CNT_EN
  task automatic check_cnt(input string nm, input logic [CNT_W-1:0] e_stall,
                           input logic [CNT_W-1:0] e_fwd);
    n_vec++;
    if ((bus.stall_cnt !== e_stall) || (bus.fwd_cnt !== e_fwd)) begin
      n_err++;
      $display("FAIL %s: got stall_cnt=%0d fwd_cnt=%0d, want %0d %0d",
               nm, bus.stall_cnt, bus.fwd_cnt, e_stall, e_fwd);
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;

    //           name          rst rs urs rt urt dw dm drn mw  wp en bub fa fb
    vecs.push_back(mk("reset0",     1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("reset1",     1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("add_r3",     0, 0, 0, 0, 0, 1, 0, 3, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("fwd_ex",     0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0));
    vecs.push_back(mk("fwd_mem",    0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2, 0));
    vecs.push_back(mk("lw_r5",      0, 0, 0, 0, 0, 1, 1, 5, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("ldst",       0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk("fwd_load",   0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 1, 0, 0, 3));
    idx_t3 = vecs.size() - 1;
    vecs.push_back(mk("add_r7a",    0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("add_r7b",    0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("ex_prio",    0, 7, 1, 7, 1, 0, 0, 0, 0,  1, 1, 0, 1, 1));
    vecs.push_back(mk("mem_both",   0, 7, 1, 7, 1, 0, 0, 0, 0,  1, 1, 0, 2, 2));
    vecs.push_back(mk("lw_r5_b",    0, 0, 0, 0, 0, 1, 1, 5, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("freeze1",    0, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("freeze2",    0, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("freeze3",    0, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("ldst_after", 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk("fwd_load_b", 0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 1, 0, 0, 3));
    vecs.push_back(mk("wr_r0",      0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("r0_ex",      0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("r0_mem",     0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("lw_r0",      0, 0, 0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("r0_load",    0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("lw_r5_c",    0, 0, 0, 0, 0, 1, 1, 5, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("freeze_c",   0, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("rst_freeze", 1, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    idx_rst = vecs.size() - 1;
    vecs.push_back(mk("post_rst",   0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("add_r9",     0, 0, 0, 0, 0, 1, 0, 9, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk("nouse_r9",   0, 9, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));

    // Hold reset across one edge so shadow state is defined before the first row
    reset        = 1'b1;
    bus.rs       = '0;
    bus.rt       = '0;
    bus.use_rs   = 1'b0;
    bus.use_rt   = 1'b0;
    bus.dwreg    = 1'b0;
    bus.dm2reg   = 1'b0;
    bus.drn      = '0;
    bus.mem_wait = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
`ifdef HAZARD_CNT_EN
      if (i == idx_t3) check_cnt("cnt_after_t3", 1, 3);
      if (i == idx_rst) check_cnt("cnt_after_rst", 0, 0);
`endif
    end

    // Freeze while a forwardable ALU result sits in EX: EX must hold through the freeze
    step(mk("hs_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    step(mk("hs_add_r3",    0, 0, 0, 0, 0, 1, 0, 3, 0,  1, 1, 0, 0, 0));
    step(mk("hs_frz_ex1",   0, 3, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0));
    step(mk("hs_frz_ex2",   0, 3, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0));
    step(mk("hs_rel_ex",    0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0));
    step(mk("hs_rel_mem",   0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2, 0));
`ifdef HAZARD_CNT_EN
    check_cnt("cnt_end", 0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run cannot hang
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
